// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch: instruction fetch unit
//   Takes the current fetch address from the program counter and issues
//   instruction-memory requests. It returns an advance strobe to the PC and
//   buffers returned words with their PCs in an in-order queue. The queue
//   head is presented to decode with a valid/ready handshake. A redirect
//   flushes the queue and squashes every fetch still in flight.
//
// Ports
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   pc_i                 current fetch address
//   incr_pc_o            PC advance strobe (asserted in the grant cycle)
//   flush_i              redirect; the PC loads the branch target next cycle
//   imem_req_o/addr_o    memory request valid / address (addr = pc_i)
//   imem_gnt_i           memory accepted the request this cycle
//   imem_rvalid_i/rdata  in-order response, at least 1 cycle after grant
//   instr_valid_o        queue head valid
//   instr_ready_i        decode accepts the head
//   instr_o/instr_pc_o   head word and its PC (NOP_INSTR / 0 when empty)
// ---------------------------------------------------------------------------

// Generic in-order FIFO with synchronous clear; pointers wrap at DEPTH.
// Latency: a pushed word is visible on head_dat_o the cycle after the push.
// Backpressure: push when full is dropped unless a pop happens in the same cycle.
module ifetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  // Explicit wrap so depths that are not a power of two also work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(DEPTH - 1)) begin
      r = '0;
    end else begin
      r = p + PW'(1);
    end
    return r;
  endfunction

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    // A pop frees the slot the push needs, so push+pop is legal when full.
    push_ok  = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q gates every use of the contents.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// Fetch unit: PC -> imem requests -> in-order instruction queue -> decode.
// Latency: grant at N, rvalid at N+1, instr_valid_o at N+2.
// Backpressure: a stalled decode fills the queue; the credit rule then stops requests and PC advance.
module ifetch #(
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INSTR       = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] pc_i,
  output logic        incr_pc_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } iq_entry_t;

  // The address FIFO holds exactly the granted-but-unanswered requests, so
  // its occupancy is the outstanding count.
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_q, discard_d;
  logic [QW-1:0] iq_count;
  logic [31:0]   rsp_addr;
  iq_entry_t     iq_push_dat;
  iq_entry_t     iq_head;
  logic          outstanding_ok;
  logic          credit_ok;
  logic          grant;
  logic          rsp;
  logic          rsp_keep;
  logic          iq_pop;

  // Every in-flight request owns a queue slot, so a response never finds
  // the queue full.
  assign outstanding_ok = (int'(outstanding) < MAX_OUTSTANDING);
  assign credit_ok      = ((int'(outstanding) + int'(iq_count)) < FIFO_DEPTH);

  // rst_n_i gates the request so that it is low while reset is held even
  // though the empty-state credit would otherwise allow one.
  assign imem_req_o  = rst_n_i && !flush_i && outstanding_ok && credit_ok;
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign incr_pc_o   = grant;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp      = imem_rvalid_i && (outstanding != '0);
  // Responses to requests issued before a redirect are squashed, including
  // one that lands in the flush cycle itself.
  assign rsp_keep = rsp && (discard_q == '0) && !flush_i;

  assign instr_valid_o = (iq_count != '0);
  // Flush wins over the pop: the whole queue is being discarded anyway.
  assign iq_pop        = instr_valid_o && instr_ready_i && !flush_i;

  assign iq_push_dat = '{pc: rsp_addr, instr: imem_rdata_i};
  assign instr_o     = instr_valid_o ? iq_head.instr : NOP_INSTR;
  assign instr_pc_o  = instr_valid_o ? iq_head.pc : 32'h0;

  // discard counts how many of the in-flight responses are stale. On a
  // flush every request still in flight after this cycle becomes stale,
  // which also covers a flush arriving while older stale ones remain.
  always_comb begin
    discard_d = discard_q;
    if (flush_i) begin
      discard_d = outstanding - OW'(rsp);
    end else if (rsp && (discard_q != '0)) begin
      discard_d = discard_q - OW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
    end
  end

  // Address of each granted request, consumed in order by its response.
  ifetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (1'b0),
    .push_i     (grant),
    .push_dat_i (pc_i),
    .pop_i      (rsp),
    .head_dat_o (rsp_addr),
    .count_o    (outstanding)
  );

  // Instruction queue towards decode, cleared on redirect.
  ifetch_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (flush_i),
    .push_i     (rsp_keep),
    .push_dat_i (iq_push_dat),
    .pop_i      (iq_pop),
    .head_dat_o (iq_head),
    .count_o    (iq_count)
  );

endmodule
